nn_neuron_mac: RTL and testbench
================================

# nn_neuron_mac

Sequential multiply-accumulate engine that computes one MLP neuron: it streams FAN_IN activations, multiplies each by a weight fetched from the synchronous parameter ROM, adds the neuron bias, applies ReLU and emits one Q16.16 result. It sits directly downstream of the parameter package and memory images and feeds the layer output buffer. Arithmetic widths and Q formats follow the package constants: activations/outputs Q16.16 (32-bit), weights/biases Q2.14 (16-bit).

## Interface
- FAN_IN, 15, activations per neuron, 1..255
- ACT_WIDTH, 32, activation/output width, Q16.16
- PARAM_WIDTH, 16, weight/bias width, Q2.14
- ACC_WIDTH, 56, signed accumulator width, Q.30 domain
- APPLY_RELU, 1, 1 = ReLU on output, 0 = pass-through
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a neuron; sampled only in IDLE
- bias  in  16  signed Q2.14; sampled on accepted start
- act_valid  in  1  activation valid
- act_ready  out  1  activation accepted when valid && ready
- act_data  in  32  signed Q16.16 activation
- weight_addr  out  8  weight index to ROM, registered
- weight_data  in  16  signed Q2.14; ROM data for address presented previous cycle
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  32  signed Q16.16 result
- overflow  out  1  result was clamped; valid with out_valid
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, FINISH, OUT.
- IDLE: busy=0, act_ready=0. start=1 -> acc cleared, bias latched, weight_addr=0, count=0, go ACCUM.
- ACCUM: act_ready=1. On handshake: act_q<=act_data, mac_v<=1, count++, weight_addr++ (holds at last index). Handshake with count==FAN_IN-1 -> DRAIN (act_ready deasserts same edge). act_valid gaps allowed, no timeout.
- MAC stage: cycle after each handshake, acc += sext(act_q)*sext(weight_data) (48-bit product, Q18.30).
- DRAIN: one cycle for the final MAC -> FINISH.
- FINISH: sum = acc + (sext(bias) <<< 16); result = sum >>> 14 (arithmetic, truncate toward −inf); saturate/wrap to 32 bits; if APPLY_RELU and negative -> 0. Register into out_data/overflow, out_valid=1, go OUT.
- OUT: hold out_data/out_valid/overflow stable until out_ready; on handshake -> IDLE, out_valid=0 next cycle.
- start outside IDLE ignored. act_valid outside ACCUM ignored.
- Overflow in acc itself impossible for FAN_IN≤255 at ACC_WIDTH 56.
- Reset (any time, including mid-accumulate): all state cleared, no partial output.

## Timing
- Reset values: act_ready=0, weight_addr=0, out_valid=0, out_data=0, overflow=0, busy=0, state IDLE.
- weight_addr equals index of next activation to accept; ROM latency fixed at 1 cycle.
- out_valid rises 3 edges after the edge accepting the last activation (MAC, DRAIN, FINISH).
- Minimum neuron time with continuous act_valid and out_ready=1: 1 (start) + FAN_IN + 3 + 1 (out handshake) cycles.
- Back-to-back: start accepted cycle after out handshake.
- out_ready held low: all outputs stable indefinitely.

## Configuration
- NN_NEURON_MAC_SATURATE_EN defined: result outside 32-bit signed range clamps to 0x7FFFFFFF / 0x80000000 and overflow=1 (ReLU applied after clamp).
- Not defined: result = low 32 bits of shifted sum (two's-complement wrap); overflow tied 0.

## Test plan
- FAN_IN=1, act 0x00010000 (1.0), weight 0x2000 (0.5), bias 0x1000 (0.25) -> out_data 0x0000C000, overflow 0, out_valid 3 edges after act handshake.
- FAN_IN=1, act 0x00010000, weight 0xC000 (−1.0), bias 0: APPLY_RELU=1 -> 0x00000000; APPLY_RELU=0 -> 0xFFFF0000.
- FAN_IN=15, act 0x7FFF0000 each, weight 0x7FFF, bias 0 -> with macro 0x7FFFFFFF and overflow 1; without macro wrapped value, overflow 0.
- FAN_IN=15, random act_valid gaps, weights w[k]=k*0x0400 -> weight_addr sequence 0..14 matches accepted activations; out_data equals reference model bit-exact.
- out_ready low 5 cycles after out_valid -> out_data stable; start pulses during that time ignored; next start accepted cycle after handshake.
- rst_n asserted after 7 of 15 activations -> all outputs reset values immediately; fresh neuron afterwards produces correct result with no residue.

Source files
------------

// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac: sequential multiply-accumulate engine for one MLP neuron.
// Streams FAN_IN Q16.16 activations and multiplies each by a Q2.14 weight
// from a synchronous ROM (1-cycle latency). It accumulates the products in
// the Q.30 domain, adds the bias, rescales to Q16.16, optionally applies
// ReLU, and presents the result on a valid/ready output.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 begin a neuron (IDLE only); bias sampled with it
//   act_valid/act_ready   activation handshake, act_data Q16.16
//   weight_addr           registered ROM index of next activation
//   weight_data           ROM data for address presented previous cycle
//   out_valid/out_ready   result handshake, out_data Q16.16
//   overflow              result was clamped (valid with out_valid)
//   busy                  high in any state except IDLE
//
// Build option: NN_NEURON_MAC_SATURATE_EN selects clamping of out-of-range
// results (with overflow flag); otherwise the result wraps and overflow=0.
module nn_neuron_mac #(
  parameter int unsigned FAN_IN      = 15,
  parameter int unsigned ACT_WIDTH   = 32,
  parameter int unsigned PARAM_WIDTH = 16,
  parameter int unsigned ACC_WIDTH   = 56,
  parameter bit          APPLY_RELU  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [PARAM_WIDTH-1:0] bias,
  input  logic                   act_valid,
  output logic                   act_ready,
  input  logic [ACT_WIDTH-1:0]   act_data,
  output logic [7:0]             weight_addr,
  input  logic [PARAM_WIDTH-1:0] weight_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACT_WIDTH-1:0]   out_data,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned PROD_WIDTH = ACT_WIDTH + PARAM_WIDTH;
  // Q.30 accumulator -> Q.16 result
  localparam int unsigned SHR        = 14;
  localparam int unsigned HI_WIDTH   = ACC_WIDTH - SHR;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINISH, OUT} state_t;

  state_t                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [PARAM_WIDTH-1:0]      bias_q;
  logic [ACT_WIDTH-1:0]        act_q;
  logic                        mac_v_q;
  logic [7:0]                  count_q;
  logic [7:0]                  addr_q;
  logic [ACT_WIDTH-1:0]        out_q;

  logic                         handshake;
  logic                         last;
  logic signed [PROD_WIDTH-1:0] act_ext, wgt_ext, prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic [ACT_WIDTH-1:0]         clamped;
  logic [ACT_WIDTH-1:0]         result;

  assign handshake = act_valid && act_ready;
  assign last      = (count_q == 8'(FAN_IN - 1));

  // Full-precision signed product, sign-extended into the accumulator.
  always_comb begin
    act_ext  = {{PARAM_WIDTH{act_q[ACT_WIDTH-1]}}, act_q};
    wgt_ext  = {{ACT_WIDTH{weight_data[PARAM_WIDTH-1]}}, weight_data};
    prod     = act_ext * wgt_ext;
    prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  end

  // (acc + (bias <<< 16)) >>> 14 equals (acc >>> 14) + (bias << 2) exactly,
  // because the shifted bias has no bits below position 16.
`ifdef NN_NEURON_MAC_SATURATE_EN
  logic [HI_WIDTH-1:0] shifted, bias_term;
  logic                fits;
  logic                result_ovf;
  logic                ovf_q;

  always_comb begin
    bias_term = {{(HI_WIDTH-PARAM_WIDTH-2){bias_q[PARAM_WIDTH-1]}}, bias_q, 2'b00};
    shifted   = acc_q[ACC_WIDTH-1:SHR] + bias_term;
    fits      = (&shifted[HI_WIDTH-1:ACT_WIDTH-1]) | ~(|shifted[HI_WIDTH-1:ACT_WIDTH-1]);
    clamped    = shifted[ACT_WIDTH-1:0];
    result_ovf = 1'b0;
    if (!fits) begin
      result_ovf = 1'b1;
      clamped    = shifted[HI_WIDTH-1] ? {1'b1, {(ACT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACT_WIDTH-1){1'b1}}};
    end
  end

  assign overflow = ovf_q;
`else
  logic [ACT_WIDTH-1:0] shifted, bias_term;

  always_comb begin
    bias_term = {{(ACT_WIDTH-PARAM_WIDTH-2){bias_q[PARAM_WIDTH-1]}}, bias_q, 2'b00};
    shifted   = acc_q[ACT_WIDTH+SHR-1:SHR] + bias_term;
    clamped   = shifted;
  end

  assign overflow = 1'b0;
`endif

  always_comb begin
    result = clamped;
    if (APPLY_RELU && clamped[ACT_WIDTH-1]) result = '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (handshake && last) state_d = DRAIN;
      // leave only once the final product has been folded into acc_q
      DRAIN:   if (!mac_v_q) state_d = FINISH;
      FINISH:  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    act_ready   = (state_q == ACCUM);
    out_valid   = (state_q == OUT);
    busy        = (state_q != IDLE);
    weight_addr = addr_q;
    out_data    = out_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      bias_q  <= '0;
      act_q   <= '0;
      mac_v_q <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      out_q   <= '0;
`ifdef NN_NEURON_MAC_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      mac_v_q <= handshake;
      if (handshake) act_q <= act_data;
      if (mac_v_q)   acc_q <= acc_q + prod_ext;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            bias_q  <= bias;
            addr_q  <= '0;
            count_q <= '0;
          end
        end
        ACCUM: begin
          if (handshake) begin
            count_q <= count_q + 8'd1;
            if (!last) addr_q <= addr_q + 8'd1;
          end
        end
        FINISH: begin
          out_q <= result;
`ifdef NN_NEURON_MAC_SATURATE_EN
          ovf_q <= result_ovf;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed bench for nn_neuron_mac. Two FAN_IN=1 instances (ReLU on/off)
// share one stimulus group, two FAN_IN=15 instances (ReLU on/off) share
// another. Each instance has its own 1-cycle-latency ROM read register.
module tb_nn_neuron_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  // group A: FAN_IN = 1
  logic        a_start, a_act_valid, a_out_ready;
  logic [15:0] a_bias;
  logic [31:0] a_act_data;
  logic [15:0] rom_a [0:255];
  logic        a1_act_ready, a0_act_ready, a1_out_valid, a0_out_valid;
  logic        a1_ovf, a0_ovf, a1_busy, a0_busy;
  logic [7:0]  a1_addr, a0_addr;
  logic [15:0] a1_wd, a0_wd;
  logic [31:0] a1_out_data, a0_out_data;

  // group B: FAN_IN = 15
  logic        b_start, b_act_valid, b_out_ready;
  logic [15:0] b_bias;
  logic [31:0] b_act_data;
  logic [15:0] rom_b [0:255];
  logic [31:0] b_act [0:14];
  logic        b1_act_ready, b0_act_ready, b1_out_valid, b0_out_valid;
  logic        b1_ovf, b0_ovf, b1_busy, b0_busy;
  logic [7:0]  b1_addr, b0_addr;
  logic [15:0] b1_wd, b0_wd;
  logic [31:0] b1_out_data, b0_out_data;

  always @(posedge clk) begin
    a1_wd <= rom_a[a1_addr];
    a0_wd <= rom_a[a0_addr];
    b1_wd <= rom_b[b1_addr];
    b0_wd <= rom_b[b0_addr];
  end

  nn_neuron_mac #(.FAN_IN(1), .APPLY_RELU(1'b1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bias(a_bias),
    .act_valid(a_act_valid), .act_ready(a1_act_ready), .act_data(a_act_data),
    .weight_addr(a1_addr), .weight_data(a1_wd),
    .out_valid(a1_out_valid), .out_ready(a_out_ready), .out_data(a1_out_data),
    .overflow(a1_ovf), .busy(a1_busy));

  nn_neuron_mac #(.FAN_IN(1), .APPLY_RELU(1'b0)) u_a0 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .bias(a_bias),
    .act_valid(a_act_valid), .act_ready(a0_act_ready), .act_data(a_act_data),
    .weight_addr(a0_addr), .weight_data(a0_wd),
    .out_valid(a0_out_valid), .out_ready(a_out_ready), .out_data(a0_out_data),
    .overflow(a0_ovf), .busy(a0_busy));

  nn_neuron_mac #(.FAN_IN(15), .APPLY_RELU(1'b1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bias(b_bias),
    .act_valid(b_act_valid), .act_ready(b1_act_ready), .act_data(b_act_data),
    .weight_addr(b1_addr), .weight_data(b1_wd),
    .out_valid(b1_out_valid), .out_ready(b_out_ready), .out_data(b1_out_data),
    .overflow(b1_ovf), .busy(b1_busy));

  nn_neuron_mac #(.FAN_IN(15), .APPLY_RELU(1'b0)) u_b0 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .bias(b_bias),
    .act_valid(b_act_valid), .act_ready(b0_act_ready), .act_data(b_act_data),
    .weight_addr(b0_addr), .weight_data(b0_wd),
    .out_valid(b0_out_valid), .out_ready(b_out_ready), .out_data(b0_out_data),
    .overflow(b0_ovf), .busy(b0_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with group A idle; returns at the negedge where
  // out_valid is first seen, lat = edges after the activation handshake.
  task automatic run_a(input logic [31:0] act, input logic [15:0] w,
                       input logic [15:0] bias, output int l);
    rom_a[0] = w;
    a_bias   = bias;
    a_start  = 1'b1;
    @(negedge clk);
    a_start     = 1'b0;
    a_act_valid = 1'b1;
    a_act_data  = act;
    check("a1_ready", a1_act_ready, 1'b1);
    check("a0_ready", a0_act_ready, 1'b1);
    @(negedge clk);
    a_act_valid = 1'b0;
    l = 0;
    while (!a1_out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic b_go(input logic [15:0] bias);
    b_bias  = bias;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic b_feed(input int n, input bit gaps, input bit chk);
    int g;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          b_act_valid = 1'b0;
          b_act_data  = 32'hDEAD_BEEF;
          @(negedge clk);
        end
      end
      b_act_valid = 1'b1;
      b_act_data  = b_act[k];
      if (chk) check($sformatf("b_addr[%0d]", k), {24'd0, b1_addr}, k);
      @(negedge clk);
    end
    b_act_valid = 1'b0;
    b_act_data  = '0;
  endtask

  task automatic b_wait(output int l);
    l = 0;
    while (!b1_out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    a_start = 1'b0; a_act_valid = 1'b0; a_out_ready = 1'b1; a_bias = '0; a_act_data = '0;
    b_start = 1'b0; b_act_valid = 1'b0; b_out_ready = 1'b1; b_bias = '0; b_act_data = '0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_act_ready", b1_act_ready, 1'b0);
    check("rst_addr",      {24'd0, b1_addr}, 32'd0);
    check("rst_out_valid", b1_out_valid, 1'b0);
    check("rst_out_data",  b1_out_data, 32'd0);
    check("rst_overflow",  b1_ovf, 1'b0);
    check("rst_busy",      b1_busy, 1'b0);
    check("rst_a_busy",    a1_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 * 0.5 + 0.25 = 0.75
    run_a(32'h0001_0000, 16'h2000, 16'h1000, lat);
    check("t1_latency", lat, 32'd3);
    check("t1_a1_data", a1_out_data, 32'h0000_C000);
    check("t1_a0_data", a0_out_data, 32'h0000_C000);
    check("t1_a1_ovf",  a1_ovf, 1'b0);
    check("t1_a0_busy", a0_busy, 1'b1);
    @(negedge clk);
    check("t1_idle_valid", a1_out_valid, 1'b0);
    check("t1_idle_busy",  a1_busy, 1'b0);

    // 1.0 * -1.0 + 0: ReLU clamps to 0, pass-through gives -1.0
    run_a(32'h0001_0000, 16'hC000, 16'h0000, lat);
    check("t2_latency", lat, 32'd3);
    check("t2_relu_data", a1_out_data, 32'h0000_0000);
    check("t2_pass_data", a0_out_data, 32'hFFFF_0000);
    check("t2_pass_ovf",  a0_ovf, 1'b0);
    @(negedge clk);

    // w[k] = k/16, act alternates 1.5 / -1.0, bias 0.5, random valid gaps:
    // 1.5*56/16 - 49/16 + 0.5 = 2.6875 = 0x0002B000. Output held back.
    for (int k = 0; k < 15; k++) begin
      rom_b[k] = 16'(k * 1024);
      b_act[k] = (k % 2 == 0) ? 32'h0001_8000 : 32'hFFFF_0000;
    end
    b_out_ready = 1'b0;
    b_go(16'h2000);
    check("t4_busy", b1_busy, 1'b1);
    b_feed(15, 1'b1, 1'b1);
    b_wait(lat);
    check("t4_latency", lat, 32'd3);
    check("t4_b1_data", b1_out_data, 32'h0002_B000);
    check("t4_b0_data", b0_out_data, 32'h0002_B000);
    check("t4_b1_ovf",  b1_ovf, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b_start = i[0];
      @(negedge clk);
      check("t5_hold_data",  b1_out_data, 32'h0002_B000);
      check("t5_hold_valid", b1_out_valid, 1'b1);
    end
    b_start     = 1'b0;
    b_out_ready = 1'b1;
    @(negedge clk);
    check("t5_post_valid", b1_out_valid, 1'b0);
    check("t5_post_busy",  b1_busy, 1'b0);

    // back-to-back start; 15 * 0x7FFF0000 * 0x7FFF overflows 32 bits
    for (int k = 0; k < 15; k++) begin
      rom_b[k] = 16'h7FFF;
      b_act[k] = 32'h7FFF_0000;
    end
    b_go(16'h0000);
    check("t5_b2b_busy",  b1_busy, 1'b1);
    check("t5_b2b_ready", b1_act_ready, 1'b1);
    b_feed(15, 1'b0, 1'b0);
    b_wait(lat);
    check("t3_latency", lat, 32'd3);
`ifdef NN_NEURON_MAC_SATURATE_EN
    check("t3_b0_data", b0_out_data, 32'h7FFF_FFFF);
    check("t3_b0_ovf",  b0_ovf, 1'b1);
    check("t3_b1_data", b1_out_data, 32'h7FFF_FFFF);
    check("t3_b1_ovf",  b1_ovf, 1'b1);
`else
    check("t3_b0_data", b0_out_data, 32'hFFC4_003C);
    check("t3_b0_ovf",  b0_ovf, 1'b0);
    check("t3_b1_data", b1_out_data, 32'h0000_0000);
    check("t3_b1_ovf",  b1_ovf, 1'b0);
`endif
    @(negedge clk);

    // reset after 7 of 15 activations
    b_go(16'h4000);
    b_feed(7, 1'b0, 1'b0);
    check("t6_busy_before", b1_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_act_ready", b1_act_ready, 1'b0);
    check("t6_addr",      {24'd0, b1_addr}, 32'd0);
    check("t6_out_valid", b1_out_valid, 1'b0);
    check("t6_out_data",  b0_out_data, 32'd0);
    check("t6_overflow",  b0_ovf, 1'b0);
    check("t6_busy",      b1_busy, 1'b0);
    check("t6_b0_busy",   b0_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // fresh neuron: sum k/16 for k=0..14 = 6.5625 = 0x00069000
    for (int k = 0; k < 15; k++) begin
      rom_b[k] = 16'(k * 1024);
      b_act[k] = 32'h0001_0000;
    end
    b_go(16'h0000);
    b_feed(15, 1'b0, 1'b1);
    b_wait(lat);
    check("t6_latency", lat, 32'd3);
    check("t6_b1_data", b1_out_data, 32'h0006_9000);
    check("t6_b0_data", b0_out_data, 32'h0006_9000);
    check("t6_b1_ovf",  b1_ovf, 1'b0);
    @(negedge clk);
    check("t6_idle", b1_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
